// File: rtl/ext_fib_if.sv
// Handshake and operand bundle for ext_fib_unit. The master drives the request
// and operands; the slave returns status and the result.
interface ext_fib_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] n;
  logic [N-1:0] f0;
  logic [N-1:0] f1;
  logic [N-1:0] coef_a;
  logic [N-1:0] coef_b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         ovf;

  modport master (
    output start, n, f0, f1, coef_a, coef_b,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, n, f0, f1, coef_a, coef_b,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/ext_fib_unit.sv
// Generalised Fibonacci term generator: f(k) = a*f(k-1) + b*f(k-2) mod 2^N,
// one iteration per clock, with a sticky overflow flag per computation.
module ext_fib_unit #(
  parameter int N = 8
) (
  input  logic      clk,
  input  logic      rst,
  ext_fib_if.slave  bus
);

  localparam int SW = 2 * N + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_p;
  logic [N-1:0] r_q;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_result;
  logic         r_ovf;
  logic         w_busy;
  logic         w_done;
  logic [SW-1:0] w_sum;

  function automatic logic [N-1:0] trunc_n(input logic [SW-1:0] s);
    return s[N-1:0];
  endfunction

  function automatic logic sum_ovf(input logic [SW-1:0] s);
    return |s[SW-1:N];
  endfunction

  // Full-precision sum so overflow detection sees every carried-out bit
  assign w_sum = (SW'(r_a) * SW'(r_p)) + (SW'(r_b) * SW'(r_q));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt < N'(2)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_p      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_p   <= bus.f1;
            r_q   <= bus.f0;
            r_cnt <= bus.n;
            r_a   <= bus.coef_a;
            r_b   <= bus.coef_b;
            r_ovf <= 1'b0;
          end
        end
        S_CALC: begin
          // cnt counts down to 1 and never wraps, so n = 2^N-1 terminates
          if (r_cnt >= N'(2)) begin
            r_p   <= trunc_n(w_sum);
            r_q   <= r_p;
            r_cnt <= r_cnt - N'(1);
            if (sum_ovf(w_sum)) r_ovf <= 1'b1;
          end else if (r_cnt == N'(1)) begin
            r_result <= r_p;
          end else begin
            r_result <= r_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_ext_fib_unit.sv
// Directed and randomized bench for ext_fib_unit against a plain-arithmetic
// model of the recurrence.
module tb_ext_fib_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  ext_fib_if #(.N(8)) bus ();

  ext_fib_unit #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: iterate the recurrence term by term on plain integers
  task automatic model(input int nn, input int f0v, input int f1v, input int av,
                       input int bv, output int r, output int o);
    int fk2, fk1, t;
    fk2 = f0v;
    fk1 = f1v;
    o   = 0;
    if (nn == 0) begin
      r = f0v;
    end else begin
      for (int k = 2; k <= nn; k++) begin
        t = av * fk1 + bv * fk2;
        if (t > 255) o = 1;
        fk2 = fk1;
        fk1 = t % 256;
      end
      r = fk1;
    end
  endtask

  task automatic set_ops(input int nn, input int f0v, input int f1v, input int av, input int bv);
    bus.n      = 8'(nn);
    bus.f0     = 8'(f0v);
    bus.f1     = 8'(f1v);
    bus.coef_a = 8'(av);
    bus.coef_b = 8'(bv);
  endtask

  task automatic scramble();
    bus.start  = 1'($urandom);
    bus.n      = 8'($urandom);
    bus.f0     = 8'($urandom);
    bus.f1     = 8'($urandom);
    bus.coef_a = 8'($urandom);
    bus.coef_b = 8'($urandom);
  endtask

  // Start one computation from IDLE and check latency, result, ovf and the DONE->IDLE return
  task automatic run(input string tag, input int nn, input int f0v, input int f1v,
                     input int av, input int bv, input bit disturb);
    int exp_r, exp_o, lat, exp_lat;
    model(nn, f0v, f1v, av, bv, exp_r, exp_o);
    exp_lat = (nn < 1) ? 1 : nn;
    set_ops(nn, f0v, f1v, av, bv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (disturb) scramble();
      if (k == 1 || k == exp_lat - 1) chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_r));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_o));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'(1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
    chk({tag, "_idle"}, 32'(bus.busy), 32'(0));
    chk({tag, "_hold_result"}, 32'(bus.result), 32'(exp_r));
    chk({tag, "_hold_ovf"}, 32'(bus.ovf), 32'(exp_o));
  endtask

  initial begin
    int sr, so, nn;
    bus.start = 1'b1;
    set_ops(10, 0, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_ovf", 32'(bus.ovf), 32'(0));
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    run("fib10", 10, 0, 1, 1, 1, 1'b0);
    chk("fib10_const", 32'(bus.result), 32'(55));
    run("fib14", 14, 0, 1, 1, 1, 1'b0);
    chk("fib14_const", 32'(bus.result), 32'(121));
    chk("fib14_ovf_const", 32'(bus.ovf), 32'(1));
    run("fib13", 13, 0, 1, 1, 1, 1'b0);
    chk("fib13_const", 32'(bus.result), 32'(233));
    chk("fib13_ovf_const", 32'(bus.ovf), 32'(0));
    run("n0", 0, 7, 9, 1, 1, 1'b0);
    chk("n0_const", 32'(bus.result), 32'(7));
    run("n1", 1, 7, 9, 1, 1, 1'b0);
    chk("n1_const", 32'(bus.result), 32'(9));
    run("a2b3", 3, 1, 1, 2, 3, 1'b1);
    chk("a2b3_const", 32'(bus.result), 32'(13));

    // Idle with start low keeps result and ovf
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", 32'(bus.result), 32'(13));

    // Abort mid-CALC with start asserted alongside rst
    set_ops(10, 0, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_result", 32'(bus.result), 32'(0));
    chk("abort_ovf", 32'(bus.ovf), 32'(0));
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(bus.done), 32'(0));
    end
    run("restart5", 5, 0, 1, 1, 1, 1'b0);
    chk("restart5_const", 32'(bus.result), 32'(5));

    // Start held high: accept, CALC, CALC->DONE, IDLE, re-accept
    set_ops(2, 0, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("held_done", 32'(bus.done), 32'((k % 4) == 2));
      chk("held_busy", 32'(bus.busy), 32'((k % 4) != 3));
      if ((k % 4) == 2) chk("held_result", 32'(bus.result), 32'(1));
    end
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run("nmax", 255, 0, 1, 1, 1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      nn = int'($urandom_range(0, 40));
      if (i % 3 == 0) run("rand_small", nn, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
      else run("rand", nn, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
    end

    model(14, 0, 1, 1, 1, sr, so);
    chk("model_sanity", 32'(sr), 32'(121));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
